// File: rtl/pipe_rca_pkg.sv
// Shared types and elaboration helpers for the pipelined ripple-carry adder/subtractor.
package pipe_rca_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int unsigned chunk_width(int unsigned width, int unsigned stages);
    return width / stages;
  endfunction

  // Legal shapes: 1..WIDTH stages, each slice the same width.
  function automatic bit cfg_ok(int unsigned width, int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational W-bit ripple-carry slice built from per-bit full-adder equations.
module rca_slice
  import pipe_rca_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  always_comb begin
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipe_rca.sv
// Pipelined ripple-carry adder/subtractor, one CHUNK-bit slice per stage, valid/ready on both ends.
// Optional signed-overflow output enabled by defining PIPE_RCA_OVF_EN.
module pipe_rca
  import pipe_rca_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero
`ifdef PIPE_RCA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipe_rca: STAGES must be in 1..WIDTH and divide WIDTH");
  end

  logic adv;
  op_e  op;

  assign op       = op_e'(sub);
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage k holds the low (k+1)*CHUNK result bits plus the operand bits not yet summed,
  // right-justified so every slice reads the bottom CHUNK bits of its remainder.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Lo   = k * CHUNK;
    localparam int unsigned RemW = WIDTH - Lo;

    logic                v_in;
    logic                c_in;
    logic [RemW-1:0]     ra_in;
    logic [RemW-1:0]     rb_in;
    logic [Lo+CHUNK-1:0] s_d;
    logic [CHUNK-1:0]    slice_s;
    logic                slice_c;
    logic                v_q;
    logic                c_q;
    logic [Lo+CHUNK-1:0] s_q;

    if (k == 0) begin : g_head
      assign v_in  = in_valid;
      assign c_in  = (op == OP_SUB) ? 1'b1 : cin;
      assign ra_in = a;
      assign rb_in = (op == OP_SUB) ? ~b : b;
      assign s_d   = slice_s;
    end else begin : g_body
      assign v_in  = g_stage[k-1].v_q;
      assign c_in  = g_stage[k-1].c_q;
      assign ra_in = g_stage[k-1].g_fwd.ra_q;
      assign rb_in = g_stage[k-1].g_fwd.rb_q;
      assign s_d   = {slice_s, g_stage[k-1].s_q};
    end

    rca_slice #(
      .W(CHUNK)
    ) u_slice (
      .a   (ra_in[CHUNK-1:0]),
      .b   (rb_in[CHUNK-1:0]),
      .cin (c_in),
      .s   (slice_s),
      .cout(slice_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_in;
      end
    end

    // Data only moves with a valid beat, so bubbles leave the last result in place.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv && v_in) begin
        c_q <= slice_c;
        s_q <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RemW-CHUNK-1:0] ra_q;
      logic [RemW-CHUNK-1:0] rb_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ra_q <= '0;
          rb_q <= '0;
        end else if (adv && v_in) begin
          ra_q <= ra_in[RemW-1:CHUNK];
          rb_q <= rb_in[RemW-1:CHUNK];
        end
      end
    end else begin : g_tail
      logic zero_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          zero_q <= 1'b0;
        end else if (adv && v_in) begin
          zero_q <= (s_d == '0);
        end
      end

`ifdef PIPE_RCA_OVF_EN
      logic ovf_q;

      // Operand sign bits sit at the top of the final remainder.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv && v_in) begin
          ovf_q <= (ra_in[CHUNK-1] == rb_in[CHUNK-1]) && (slice_s[CHUNK-1] != ra_in[CHUNK-1]);
        end
      end

      assign ovf = ovf_q;
`endif

      assign out_valid = v_q;
      assign sum       = s_q;
      assign cout      = c_q;
      assign zero      = zero_q;
    end
  end

endmodule
